rect_fill_engine: RTL and testbench

Rectangle rasteriser that serves draw requests from the UI control FSMs and turns each into a row-major stream of pixel writes for the VGA adapter. It accepts one rectangle (origin, size, colour) per handshake, emits one pixel coordinate per clock with a plot strobe, and pulses done when the rectangle is finished. It sits between the block-selection/completion controllers (initiators) and the vga_adapter x/y/colour/plot port.

---
 rtl/rect_fill_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//
// Rectangle rasteriser between the UI control FSMs and the vga_adapter.
// It accepts one rectangle (origin, size, colour) per req_valid/req_ready
// handshake. It then streams the rectangle's pixels in row-major order,
// one per clock, each with a plot strobe. When the rectangle is finished
// it raises done for one cycle.
//
// Parameters:
//   H_RES, V_RES : visible screen size in pixels
//   XW, YW       : bit widths of x/width and y/height
//
// Ports:
//   clk         : system/pixel clock
//   resetn      : synchronous, active-low reset
//   req_valid   : a rectangle request is present
//   req_ready   : engine idle; request taken when req_valid && req_ready
//   req_x/req_y : top-left corner of the rectangle
//   req_w/req_h : rectangle size in pixels (zero => no pixels, just done)
//   req_colour  : 3-bit RGB colour for the whole rectangle
//   hold        : downstream stall, freezes the scan while drawing
//   out_x/out_y : current pixel coordinate (registered)
//   out_colour  : current pixel colour (registered)
//   plot        : write strobe for out_x/out_y/out_colour (registered)
//   done        : one-cycle pulse when the rectangle is complete
//   busy        : a rectangle is in progress
//
// Optional feature macro: RECT_CLIP_EN
//   When it is defined, pixels that fall off the right or bottom of the
//   screen are scanned but not plotted. When it is undefined, every scanned
//   pixel is plotted and the coordinates wrap at 2^XW / 2^YW.

module rect_fill_engine #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [XW-1:0] req_w,
  input  logic [YW-1:0] req_h,
  input  logic [2:0]    req_colour,
  input  logic          hold,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [2:0]    out_colour,
  output logic          plot,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FINISH
  } state_t;

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [XW:0]   H_LIM = H_RES[XW:0];
  localparam logic [YW:0]   V_LIM = V_RES[YW:0];

  state_t state, state_nxt;

  logic [XW-1:0] x0_r, x0_d;
  logic [YW-1:0] y0_r, y0_d;
  logic [XW-1:0] w_r, w_d;
  logic [YW-1:0] h_r, h_d;
  logic [XW-1:0] cx_r, cx_d;
  logic [YW-1:0] cy_r, cy_d;

  logic [XW-1:0] out_x_d;
  logic [YW-1:0] out_y_d;
  logic [2:0]    out_colour_d;
  logic          plot_d;

  logic          zero_size;
  logic          last_col;
  logic          last_pix;
  logic [XW-1:0] cx_adv;
  logic [YW-1:0] cy_adv;

  logic [XW-1:0] base_x, off_x;
  logic [YW-1:0] base_y, off_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          pix_on_screen;
  logic          plot_en;

  // Scan bookkeeping. (cx_r, cy_r) is the offset of the pixel shown on the
  // outputs right now. cx_adv/cy_adv is the offset of the next pixel in
  // row-major order.
  assign zero_size = (req_w == '0) || (req_h == '0);
  assign last_col  = (cx_r == w_r - X_ONE);
  assign last_pix  = last_col && (cy_r == h_r - Y_ONE);
  assign cx_adv    = last_col ? '0 : cx_r + X_ONE;
  assign cy_adv    = last_col ? cy_r + Y_ONE : cy_r;

  // Address adder, shared by the accept cycle and the scan. On accept, the
  // pixel to register is the request origin itself. After that, it is the
  // latched origin plus the next scan offset. The sums carry one extra bit
  // so that off-screen pixels can be told apart from wrapped ones.
  always_comb begin
    base_x = x0_r;
    base_y = y0_r;
    off_x  = cx_adv;
    off_y  = cy_adv;
    if (state == IDLE) begin
      base_x = req_x;
      base_y = req_y;
      off_x  = '0;
      off_y  = '0;
    end
  end

  assign sum_x         = {1'b0, base_x} + {1'b0, off_x};
  assign sum_y         = {1'b0, base_y} + {1'b0, off_y};
  assign pix_on_screen = (sum_x < H_LIM) && (sum_y < V_LIM);

`ifdef RECT_CLIP_EN
  assign plot_en = pix_on_screen;
`else
  logic unused_on_screen;
  assign plot_en          = 1'b1;
  assign unused_on_screen = pix_on_screen;
`endif

  // State register. Reset drops any rectangle in progress on the spot, so
  // an aborted rectangle never produces a done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-sized request goes straight to FINISH, so its
  // done still arrives one cycle after accept. While hold is high, the scan
  // stays in DRAW even on the last pixel.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = zero_size ? FINISH : DRAW;
        end
      end
      DRAW: begin
        if (!hold && last_pix) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output / datapath next-value logic. Every pixel output is computed one
  // cycle ahead and registered, so plot and the coordinates never depend
  // combinationally on the inputs. The first pixel is loaded on the accept
  // edge itself. Each later non-hold edge steps to the next pixel. A hold
  // edge leaves everything frozen and drops plot, so the pixel after the
  // stall is exactly the one that would have come next.
  always_comb begin
    x0_d         = x0_r;
    y0_d         = y0_r;
    w_d          = w_r;
    h_d          = h_r;
    cx_d         = cx_r;
    cy_d         = cy_r;
    out_x_d      = out_x;
    out_y_d      = out_y;
    out_colour_d = out_colour;
    plot_d       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          x0_d         = req_x;
          y0_d         = req_y;
          w_d          = req_w;
          h_d          = req_h;
          cx_d         = '0;
          cy_d         = '0;
          out_x_d      = sum_x[XW-1:0];
          out_y_d      = sum_y[YW-1:0];
          out_colour_d = req_colour;
          plot_d       = !zero_size && plot_en;
        end
      end
      DRAW: begin
        if (!hold && !last_pix) begin
          cx_d    = cx_adv;
          cy_d    = cy_adv;
          out_x_d = sum_x[XW-1:0];
          out_y_d = sum_y[YW-1:0];
          plot_d  = plot_en;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0_r       <= '0;
      y0_r       <= '0;
      w_r        <= '0;
      h_r        <= '0;
      cx_r       <= '0;
      cy_r       <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      plot       <= 1'b0;
    end else begin
      x0_r       <= x0_d;
      y0_r       <= y0_d;
      w_r        <= w_d;
      h_r        <= h_d;
      cx_r       <= cx_d;
      cy_r       <= cy_d;
      out_x      <= out_x_d;
      out_y      <= out_y_d;
      out_colour <= out_colour_d;
      plot       <= plot_d;
    end
  end

  // Status outputs are plain decodes of the state register.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine
//
// Directed testbench for rect_fill_engine with default parameters
// (640x480 screen, XW=10, YW=9). Expected values are hand-derived from the
// scan order and the cycle timing. If RECT_CLIP_EN is defined for the
// build, the clipping expectations are used.

module tb_rect_fill_engine;

  logic       clk;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_x;
  logic [8:0] req_y;
  logic [9:0] req_w;
  logic [8:0] req_h;
  logic [2:0] req_colour;
  logic       hold;
  logic [9:0] out_x;
  logic [8:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       done;
  logic       busy;

  int assert_count = 0;
  int fail_count   = 0;

  int plots, done_k, first_k, last_k, seq_err, col_err;
  int first_px, first_py, last_px, last_py;

  rect_fill_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .hold       (hold),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .done       (done),
    .busy       (busy)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; all sampling happens here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts a failure and reports
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present a request; it is accepted on the next edge if the engine is idle
  task automatic applyStimulus(input int x, input int y, input int w,
                               input int h, input int colour);
    req_x      = 10'(x);
    req_y      = 9'(y);
    req_w      = 10'(w);
    req_h      = 9'(h);
    req_colour = 3'(colour);
    req_valid  = 1'b1;
  endtask

  // Runs the accept edge and then the scan. Each plotted pixel is checked
  // against an independent row-major walk of the rectangle. Optionally,
  // hold is raised for hold_len edges once hold_after pixels have been seen.
  // k counts cycles after the accept edge (k=1 is the first-pixel cycle).
  task automatic runScan(input int x, input int y, input int w, input int h,
                         input int colour, input int hold_after,
                         input int hold_len, input int budget);
    int         sx;
    int         sy;
    int         hold_cnt;
    bit         hold_started;
    logic [9:0] ex;
    logic [8:0] ey;
    sx = 0;
    sy = 0;
    hold_cnt = 0;
    hold_started = 1'b0;
    plots = 0;
    done_k = -1;
    first_k = -1;
    last_k = -1;
    seq_err = 0;
    col_err = 0;
    first_px = -1;
    first_py = -1;
    last_px = -1;
    last_py = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      req_valid = 1'b0;
      if (plot === 1'b1) begin
`ifdef RECT_CLIP_EN
        while (sy < h && ((x + sx) >= 640 || (y + sy) >= 480)) begin
          sx++;
          if (sx == w) begin
            sx = 0;
            sy++;
          end
        end
`endif
        ex = 10'(x + sx);
        ey = 9'(y + sy);
        if (sy >= h || out_x !== ex || out_y !== ey) seq_err++;
        if (out_colour !== 3'(colour)) col_err++;
        if (first_k < 0) begin
          first_k  = k;
          first_px = int'(out_x);
          first_py = int'(out_y);
        end
        last_k  = k;
        last_px = int'(out_x);
        last_py = int'(out_y);
        plots++;
        sx++;
        if (sx == w) begin
          sx = 0;
          sy++;
        end
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) hold = 1'b0;
      end else if (!hold_started && hold_len > 0 && plots == hold_after) begin
        hold         = 1'b1;
        hold_cnt     = hold_len;
        hold_started = 1'b1;
      end
    end
    hold = 1'b0;
  endtask

  // Full rectangle: accept, scan, then check the counts, the timing, the
  // pixel order and the single-cycle done
  task automatic doRect(input string tag, input int x, input int y,
                        input int w, input int h, input int colour,
                        input int hold_after, input int hold_len,
                        input int exp_plots, input int exp_first,
                        input int exp_last, input int exp_done);
    applyStimulus(x, y, w, h, colour);
    runScan(x, y, w, h, colour, hold_after, hold_len, exp_done + 20);
    checkOutput({tag, "/plots"}, plots, exp_plots);
    checkOutput({tag, "/first_cycle"}, first_k, exp_first);
    checkOutput({tag, "/last_cycle"}, last_k, exp_last);
    checkOutput({tag, "/done_cycle"}, done_k, exp_done);
    checkOutput({tag, "/pixel_order_errors"}, seq_err, 0);
    checkOutput({tag, "/colour_errors"}, col_err, 0);
    step();
    checkOutput({tag, "/done_one_cycle"}, done, 1'b0);
    checkOutput({tag, "/ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    int b_first_k;
    int done1_k;
    int done2_k;
    int total_plots;
    logic ready_k6;
    logic [2:0] b_colour;

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_colour = '0;
    hold       = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("reset/req_ready", req_ready, 1'b1);
    checkOutput("reset/plot", plot, 1'b0);
    checkOutput("reset/done", done, 1'b0);
    checkOutput("reset/busy", busy, 1'b0);
    checkOutput("reset/out_x", out_x, 10'd0);
    checkOutput("reset/out_y", out_y, 9'd0);
    checkOutput("reset/out_colour", out_colour, 3'd0);
    resetn = 1'b1;
    step();

    // 80x50 block: 4000 plots, first (152,226), last (231,275)
    $display("[TB] big rectangle 80x50 at (152,226)");
    doRect("big", 152, 226, 80, 50, 3'b010, 0, 0, 4000, 1, 4000, 4001);
    checkOutput("big/first_x", first_px, 152);
    checkOutput("big/first_y", first_py, 226);
    checkOutput("big/last_x", last_px, 231);
    checkOutput("big/last_y", last_py, 275);

    // 3x2 with a two-edge hold after the second pixel: done at accept+9
    $display("[TB] 3x2 rectangle with hold");
    doRect("hold", 0, 0, 3, 2, 3'b111, 2, 2, 6, 1, 8, 9);

    // Zero-width request: no plot, done at accept+1
    $display("[TB] zero-width request");
    doRect("zero", 20, 30, 0, 50, 3'b001, 0, 0, 0, -1, -1, 1);

    // Partially off-screen rectangle
    $display("[TB] rectangle crossing the screen edge");
`ifdef RECT_CLIP_EN
    doRect("edge", 630, 470, 20, 20, 3'b100, 0, 0, 100, 1, 190, 401);
    checkOutput("edge/last_x", last_px, 639);
    checkOutput("edge/last_y", last_py, 479);
`else
    doRect("edge", 630, 470, 20, 20, 3'b100, 0, 0, 400, 1, 400, 401);
    checkOutput("edge/last_x", last_px, 649);
    checkOutput("edge/last_y", last_py, 489);
`endif

    // Reset in the middle of an 80x50 rectangle after 10 pixels
    $display("[TB] reset mid-rectangle");
    applyStimulus(10, 20, 80, 50, 3'b101);
    step();
    req_valid = 1'b0;
    for (int k = 2; k <= 10; k++) step();
    checkOutput("abort/tenth_x", out_x, 10'd19);
    checkOutput("abort/tenth_plot", plot, 1'b1);
    checkOutput("abort/busy_before", busy, 1'b1);
    resetn = 1'b0;
    step();
    checkOutput("abort/plot", plot, 1'b0);
    checkOutput("abort/done", done, 1'b0);
    checkOutput("abort/req_ready", req_ready, 1'b1);
    checkOutput("abort/busy", busy, 1'b0);
    resetn = 1'b1;
    step();
    step();
    checkOutput("abort/no_late_done", done, 1'b0);
    doRect("after_abort", 5, 5, 4, 3, 3'b011, 0, 0, 12, 1, 12, 13);

    // Back-to-back: req_valid stays high across two requests
    $display("[TB] back-to-back requests");
    applyStimulus(100, 100, 2, 2, 3'b001);
    step();
    checkOutput("b2b/a_first_x", out_x, 10'd100);
    checkOutput("b2b/a_ready_low", req_ready, 1'b0);
    // Second request presented while the first draws; must not disturb it
    applyStimulus(300, 200, 2, 1, 3'b100);
    b_first_k = -1;
    done1_k = -1;
    done2_k = -1;
    total_plots = 1;
    ready_k6 = 1'b0;
    b_colour = 3'b000;
    for (int k = 2; k <= 15; k++) begin
      step();
      if (k == 2) begin
        checkOutput("b2b/a_second_x", out_x, 10'd101);
        checkOutput("b2b/a_second_y", out_y, 9'd100);
      end
      if (k == 6) ready_k6 = req_ready;
      if (plot === 1'b1) begin
        total_plots++;
        if (b_first_k < 0 && out_x === 10'd300 && out_y === 9'd200) begin
          b_first_k = k;
          b_colour  = out_colour;
          req_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        if (done1_k < 0) done1_k = k;
        else begin
          done2_k = k;
          break;
        end
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b/first_done", done1_k, 5);
    checkOutput("b2b/idle_ready", ready_k6, 1'b1);
    checkOutput("b2b/b_first_pixel", b_first_k, 7);
    checkOutput("b2b/b_colour", b_colour, 3'b100);
    checkOutput("b2b/second_done", done2_k, 9);
    checkOutput("b2b/total_plots", total_plots, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
